// File: rtl/fmul_if.sv
// Operand-issue / result-writeback handshake bundle for the pipelined FP multiplier.
// The multiplier takes the slave side; the issuer/consumer takes the master side.
interface fmul_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic             in_valid;
  logic             in_ready;
  logic [TAG_W-1:0] in_tag;
  logic [W-1:0]     srca;
  logic [W-1:0]     srcb;
  logic             out_valid;
  logic             out_ready;
  logic [TAG_W-1:0] out_tag;
  logic [W-1:0]     dst;
  logic [4:0]       flags;

  modport master (
    output in_valid, in_tag, srca, srcb, out_ready,
    input  in_ready, out_valid, out_tag, dst, flags
  );

  modport slave (
    input  in_valid, in_tag, srca, srcb, out_ready,
    output in_ready, out_valid, out_tag, dst, flags
  );
endinterface

// File: rtl/fpu_fmul_pipe.sv
// Parametrised 3-stage pipelined floating-point multiplier.
// S1: unpack, classify, mantissa multiply, exponent sum.
// S2: normalise and round-to-nearest-even.
// S3: special-case select, pack, output register.
// All stages shift together whenever the output slot is free or being drained.
module fpu_fmul_pipe #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int TAG_W  = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  fmul_if.slave bus
);

  localparam int W        = 1 + EXP_W + FRAC_W;
  localparam int MW       = FRAC_W + 1;
  localparam int PW       = 2 * MW;
  localparam int EW       = EXP_W + 2;
  localparam int BIAS     = (1 << (EXP_W - 1)) - 1;
  localparam int EXP_MAX  = (1 << EXP_W) - 1;

  localparam logic signed [EW-1:0] C_BIAS = EW'(BIAS);
  localparam logic signed [EW-1:0] C_OVF  = EW'(EXP_MAX);
  localparam logic signed [EW-1:0] C_ZERO = '0;

  localparam logic [W-1:0] C_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  // Operand class summary carried down the pipe; priority is resolved in S3.
  typedef struct packed {
    logic nan;
    logic inv;
    logic inf;
    logic zero;
  } special_t;

  // ---------------------------------------------------------------- control
  logic w_advance;
  assign w_advance    = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = w_advance;

  // ---------------------------------------------------------------- S1 comb
  logic              w_sign_a, w_sign_b;
  logic [EXP_W-1:0]  w_exp_a, w_exp_b;
  logic [FRAC_W-1:0] w_frac_a, w_frac_b;
  logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  logic [PW-1:0]     w_prod;
  logic signed [EW-1:0] w_exp_sum;
  special_t          w_special;

  assign w_sign_a = bus.srca[W-1];
  assign w_sign_b = bus.srcb[W-1];
  assign w_exp_a  = bus.srca[W-2 -: EXP_W];
  assign w_exp_b  = bus.srcb[W-2 -: EXP_W];
  assign w_frac_a = bus.srca[FRAC_W-1:0];
  assign w_frac_b = bus.srcb[FRAC_W-1:0];

  assign w_nan_a  = (&w_exp_a) && (|w_frac_a);
  assign w_nan_b  = (&w_exp_b) && (|w_frac_b);
  assign w_inf_a  = (&w_exp_a) && !(|w_frac_a);
  assign w_inf_b  = (&w_exp_b) && !(|w_frac_b);
  // Denormals are flushed to zero on input, so exp==0 alone means zero.
  assign w_zero_a = (w_exp_a == '0);
  assign w_zero_b = (w_exp_b == '0);

  assign w_special = {
    w_nan_a || w_nan_b,
    (w_inf_a && w_zero_b) || (w_zero_a && w_inf_b),
    w_inf_a || w_inf_b,
    w_zero_a || w_zero_b
  };

  assign w_prod    = PW'({1'b1, w_frac_a}) * PW'({1'b1, w_frac_b});
  assign w_exp_sum = $signed({2'b00, w_exp_a}) + $signed({2'b00, w_exp_b}) - C_BIAS;

  // ---------------------------------------------------------------- S1 regs
  logic                 r_s1_valid;
  logic [TAG_W-1:0]     r_s1_tag;
  logic                 r_s1_sign;
  special_t             r_s1_special;
  logic [PW-1:0]        r_s1_prod;
  logic signed [EW-1:0] r_s1_exp;

  // ---------------------------------------------------------------- S2 comb
  logic [PW-2:0]        w_norm;
  logic [FRAC_W-1:0]    w_frac_trunc;
  logic                 w_guard, w_rest, w_round_up, w_carry, w_n;
  logic [FRAC_W-1:0]    w_frac_rnd;
  logic signed [EW-1:0] w_exp_norm;

  // Leading one is at bit PW-1 or PW-2; align it to PW-1 and drop it.
  assign w_n          = r_s1_prod[PW-1];
  assign w_norm       = w_n ? r_s1_prod[PW-2:0] : {r_s1_prod[PW-3:0], 1'b0};
  assign w_frac_trunc = w_norm[PW-2 -: FRAC_W];
  assign w_guard      = w_norm[FRAC_W];
  assign w_rest       = |w_norm[FRAC_W-1:0];
  assign w_round_up   = w_guard && (w_rest || w_frac_trunc[0]);
  // A carry out of the fraction means it was all ones; the wrapped-to-zero
  // fraction is then exactly the renormalised 1.000... mantissa.
  assign {w_carry, w_frac_rnd} = {1'b0, w_frac_trunc} + (FRAC_W+1)'(w_round_up);
  assign w_exp_norm   = r_s1_exp
                      + $signed({{(EW-1){1'b0}}, w_n})
                      + $signed({{(EW-1){1'b0}}, w_carry});

  // ---------------------------------------------------------------- S2 regs
  logic                 r_s2_valid;
  logic [TAG_W-1:0]     r_s2_tag;
  logic                 r_s2_sign;
  special_t             r_s2_special;
  logic [FRAC_W-1:0]    r_s2_frac;
  logic signed [EW-1:0] r_s2_exp;
  logic                 r_s2_inexact;

  // ---------------------------------------------------------------- S3 comb
  logic [W-1:0] w_res;
  logic [4:0]   w_flags;

  // Special-case priority, then overflow / flush-to-zero, else the rounded number.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    w_res   = {r_s2_sign, r_s2_exp[EXP_W-1:0], r_s2_frac};
    w_flags = {3'b000, r_s2_inexact, 1'b0};
    if (r_s2_special.nan) begin
      w_res   = C_QNAN;
      w_flags = 5'b00001;
    end else if (r_s2_special.inv) begin
      w_res   = C_QNAN;
      w_flags = 5'b10000;
    end else if (r_s2_special.inf) begin
      w_res   = {r_s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_flags = 5'b00000;
    end else if (r_s2_special.zero) begin
      w_res   = {r_s2_sign, {(W-1){1'b0}}};
      w_flags = 5'b00000;
    end else if (r_s2_exp >= C_OVF) begin
      w_res   = {r_s2_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_flags = 5'b01010;
    end else if (r_s2_exp <= C_ZERO) begin
      w_res   = {r_s2_sign, {(W-1){1'b0}}};
      w_flags = 5'b00110;
    end
  end

  // ---------------------------------------------------------------- out regs
  logic             r_out_valid;
  logic [W-1:0]     r_dst;
  logic [TAG_W-1:0] r_out_tag;
  logic [4:0]       r_flags;

  // Stage valids and the visible output register; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_s1_valid  <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_dst       <= '0;
      r_out_tag   <= '0;
      r_flags     <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= bus.in_valid;
      r_s2_valid  <= r_s1_valid;
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_dst     <= w_res;
        r_out_tag <= r_s2_tag;
        r_flags   <= w_flags;
      end
    end
  end

  // Pipeline datapath registers, loaded only when a valid op moves into the stage.
  // NOTE: these carry no reset; the stage valid bits alone decide whether they are meaningful.
  always_ff @(posedge clk) begin
    if (w_advance && bus.in_valid) begin
      r_s1_tag     <= bus.in_tag;
      r_s1_sign    <= w_sign_a ^ w_sign_b;
      r_s1_special <= w_special;
      r_s1_prod    <= w_prod;
      r_s1_exp     <= w_exp_sum;
    end
    if (w_advance && r_s1_valid) begin
      r_s2_tag     <= r_s1_tag;
      r_s2_sign    <= r_s1_sign;
      r_s2_special <= r_s1_special;
      r_s2_frac    <= w_frac_rnd;
      r_s2_exp     <= w_exp_norm;
      r_s2_inexact <= w_guard || w_rest;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.dst       = r_dst;
  assign bus.out_tag   = r_out_tag;
  assign bus.flags     = r_flags;

endmodule

// File: tb/tb_fpu_fmul_pipe.sv
// Self-checking bench for fpu_fmul_pipe (default single-precision parameters).
// A value-level reference model predicts every result; a negedge monitor keeps
// an in-order scoreboard of accepted operations and checks each emitted result.
module tb_fpu_fmul_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fmul_if u_if ();

  fpu_fmul_pipe u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_out  = 0;
  logic [40:0] sb_q[$];
  bit          stall_mode = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {flags[4:0], dst[31:0]} computed from real-number rules on
  // integer mantissas (exact product, then RNE by remainder vs half-ulp).
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
    int                ea, eb, e, sh;
    logic [22:0]       fa, fb;
    logic              s, na, nb, ia, ib, za, zb, inexact;
    longint unsigned   prod, q, rem, half;
    ea = a[30:23]; eb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    s  = a[31] ^ b[31];
    na = (ea == 255) && (fa != 0);  nb = (eb == 255) && (fb != 0);
    ia = (ea == 255) && (fa == 0);  ib = (eb == 255) && (fb == 0);
    za = (ea == 0);                 zb = (eb == 0);
    if (na || nb) return {5'b00001, 32'h7FC00000};
    if ((ia && zb) || (za && ib)) return {5'b10000, 32'h7FC00000};
    if (ia || ib) return {5'b00000, s, 8'hFF, 23'd0};
    if (za || zb) return {5'b00000, s, 31'd0};
    prod = longint'({1'b1, fa}) * longint'({1'b1, fb});
    e  = ea + eb - 127;
    sh = 23;
    if (prod >= (64'd1 << 47)) begin
      sh = 24;
      e  = e + 1;
    end
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {5'b01010, s, 8'hFF, 23'd0};
    if (e <= 0)   return {5'b00110, s, 31'd0};
    return {3'b000, inexact, 1'b0, s, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 11))
      0:       e = 8'h00;
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) f = '0; end
      2:       e = 8'($urandom_range(180, 254));
      3:       e = 8'($urandom_range(1, 70));
      4:       begin e = 8'($urandom_range(120, 134)); f = 23'h7FFFFF - 23'($urandom_range(0, 3)); end
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  // out_ready: held high normally, pseudo-random while stall_mode is set.
  initial begin
    u_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      u_if.out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  end

  // Monitor / compare process, sampling mid-cycle on the falling edge.
  initial begin
    logic        held;
    logic [31:0] h_dst;
    logic [3:0]  h_tag;
    logic [4:0]  h_flags;
    logic [40:0] exp_e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (u_if.in_valid && u_if.in_ready)
          sb_q.push_back({u_if.in_tag, model(u_if.srca, u_if.srcb)});
        if (u_if.out_valid) begin
          if (held) begin
            check("stall_dst",   u_if.dst,     h_dst);
            check("stall_tag",   u_if.out_tag, h_tag);
            check("stall_flags", u_if.flags,   h_flags);
          end
          if (u_if.out_ready) begin
            held = 1'b0;
            if (sb_q.size() == 0) begin
              check("spurious_out_valid", u_if.out_valid, 1'b0);
            end else begin
              exp_e = sb_q.pop_front();
              check("dst",   u_if.dst,     exp_e[31:0]);
              check("flags", u_if.flags,   exp_e[36:32]);
              check("tag",   u_if.out_tag, exp_e[40:37]);
              n_out++;
            end
          end else begin
            held    = 1'b1;
            h_dst   = u_if.dst;
            h_tag   = u_if.out_tag;
            h_flags = u_if.flags;
          end
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n;
    n = 0;
    u_if.in_valid = 1'b1;
    u_if.srca     = a;
    u_if.srcb     = b;
    u_if.in_tag   = tag;
    @(negedge clk);
    while (!u_if.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!u_if.in_ready) check("accept_timeout", u_if.in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    u_if.in_valid = 1'b0;
    while ((sb_q.size() != 0 || u_if.out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  // Measures edges from the accepting edge (counted as 1) until out_valid.
  task automatic measure_latency(input string name);
    int lat;
    lat = 1;
    u_if.in_valid = 1'b0;
    while (!u_if.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check(name, 64'(lat), 64'd3);
  endtask

  logic [31:0] d_a   [11] = '{32'h3FC00000, 32'h3F800001, 32'hBF800000, 32'h7F000000,
                              32'h00800000, 32'h7F800000, 32'h7FC00001, 32'hFF800000,
                              32'h00000000, 32'h00000001, 32'h3F918E00};
  logic [31:0] d_b   [11] = '{32'h40000000, 32'h3F800001, 32'h3F800000, 32'h40000000,
                              32'h00800000, 32'h00000000, 32'h3F800000, 32'h40000000,
                              32'hC0000000, 32'h3F800000, 32'h3FE12000};
  logic [31:0] d_dst [11] = '{32'h40400000, 32'h3F800002, 32'hBF800000, 32'h7F800000,
                              32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000,
                              32'h80000000, 32'h00000000, 32'h40000000};
  logic [4:0]  d_flg [11] = '{5'b00000, 5'b00010, 5'b00000, 5'b01010,
                              5'b00110, 5'b10000, 5'b00001, 5'b00000,
                              5'b00000, 5'b00000, 5'b00010};

  initial begin
    int out_before;
    u_if.in_valid = 1'b0;
    u_if.in_tag   = '0;
    u_if.srca     = '0;
    u_if.srcb     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", u_if.out_valid, 1'b0);
    check("rst_dst",       u_if.dst,       32'h0);
    check("rst_tag",       u_if.out_tag,   4'h0);
    check("rst_flags",     u_if.flags,     5'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_in_ready", u_if.in_ready, 1'b1);

    // Hand-computed values pin the reference model itself.
    for (int i = 0; i < 11; i++)
      check($sformatf("model_pin%0d", i), model(d_a[i], d_b[i]), {d_flg[i], d_dst[i]});

    // First operation alone: latency and literal result.
    send(32'h3FC00000, 32'h40000000, 4'h1);
    measure_latency("latency_first");
    check("t1_dst",   u_if.dst,   32'h40400000);
    check("t1_flags", u_if.flags, 5'b00000);
    drain();

    // Directed table streamed back to back.
    for (int i = 0; i < 11; i++) send(d_a[i], d_b[i], 4'(i));
    drain();

    // Eight tagged ops with random backpressure.
    out_before = n_out;
    stall_mode = 1'b1;
    for (int i = 0; i < 8; i++) send(rand_op(), rand_op(), 4'(i + 3));
    drain();
    check("stream_count", 64'(n_out - out_before), 64'd8);

    // Randomised traffic with input gaps and output stalls.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        u_if.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end else begin
        send(rand_op(), rand_op(), 4'($urandom));
      end
    end
    drain();

    // Reset with operations in flight.
    stall_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(32'h3F800000, 32'h40000000, 4'hA);
    send(32'h40400000, 32'h40400000, 4'hB);
    send(32'h40800000, 32'h3F000000, 4'hC);
    u_if.in_valid = 1'b0;
    check("prereset_out_valid", u_if.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_out_valid", u_if.out_valid, 1'b0);
    check("reset_dst",       u_if.dst,       32'h0);
    check("reset_flags",     u_if.flags,     5'h0);
    check("reset_tag",       u_if.out_tag,   4'h0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("no_stale_out", u_if.out_valid, 1'b0);
    end
    send(32'h3FC00000, 32'hC0000000, 4'h5);
    measure_latency("latency_after_reset");
    check("post_reset_dst", u_if.dst,     32'hC0400000);
    check("post_reset_tag", u_if.out_tag, 4'h5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
